// File: rtl/mau_pkg.sv
// mau_pkg: shared state encoding and constants for the SLC-3 memory access unit.
package mau_pkg;
    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] IO_ADDR = 16'hFFFF;
    typedef enum logic [2:0] {IDLE, RD_WAIT, WR_SETUP, WR_PULSE, DONE} mau_state_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: datapath-side and SRAM-side signals of the memory access unit.
// MAU_IO_MAP_EN adds the switch input and hex display output.
interface mem_access_unit_if #(parameter int ADDR_W = 20);
    import mau_pkg::*;
    logic [WORD_W-1:0] BUS;
    logic LD_MAR, LD_MDR, MEM_REQ, MEM_WE;
    logic [WORD_W-1:0] MAR_out, MDR_out;
    logic MEM_READY, BUSY;
    logic [ADDR_W-1:0] sram_addr;
    logic [WORD_W-1:0] sram_wdata, sram_rdata;
    logic sram_ce_n, sram_oe_n, sram_we_n;
`ifdef MAU_IO_MAP_EN
    logic [WORD_W-1:0] sw_in, hex_out;
    modport slave (input BUS, LD_MAR, LD_MDR, MEM_REQ, MEM_WE, sram_rdata, sw_in,
                   output MAR_out, MDR_out, MEM_READY, BUSY, sram_addr, sram_wdata,
                   sram_ce_n, sram_oe_n, sram_we_n, hex_out);
    modport master (output BUS, LD_MAR, LD_MDR, MEM_REQ, MEM_WE, sram_rdata, sw_in,
                    input MAR_out, MDR_out, MEM_READY, BUSY, sram_addr, sram_wdata,
                    sram_ce_n, sram_oe_n, sram_we_n, hex_out);
`else
    modport slave (input BUS, LD_MAR, LD_MDR, MEM_REQ, MEM_WE, sram_rdata,
                   output MAR_out, MDR_out, MEM_READY, BUSY, sram_addr, sram_wdata,
                   sram_ce_n, sram_oe_n, sram_we_n);
    modport master (output BUS, LD_MAR, LD_MDR, MEM_REQ, MEM_WE, sram_rdata,
                    input MAR_out, MDR_out, MEM_READY, BUSY, sram_addr, sram_wdata,
                    sram_ce_n, sram_oe_n, sram_we_n);
`endif
endinterface

// File: rtl/mau_wait_counter.sv
// mau_wait_counter: load-and-count-down wait-state counter; last is high while the count is zero.
module mau_wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] count,
    output logic       last
);
    logic [3:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= start ? count : (cnt != '0 ? cnt - 4'd1 : cnt);
    assign last = cnt == '0;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: SLC-3 MAR/MDR plus fixed wait-state SRAM read/write sequencer.
// MAU_IO_MAP_EN maps address 0xFFFF to sw_in (read) and hex_out (write) instead of SRAM.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input logic Clk,
    input logic Reset,
    mem_access_unit_if.slave mau
);
    mau_state_t state;
    logic [WORD_W-1:0] mar, mdr, mar_nx, mdr_nx;
    logic ce_n, oe_n, we_n, ready, busy, io_hit, cnt_start, cnt_last;
    // Loads issued together with a request take effect first, so the access sees them.
    assign mar_nx = mau.LD_MAR ? mau.BUS : mar;
    assign mdr_nx = mau.LD_MDR ? mau.BUS : mdr;
`ifdef MAU_IO_MAP_EN
    assign io_hit = mar_nx == IO_ADDR;
`else
    assign io_hit = 1'b0;
`endif
    assign cnt_start = (state == IDLE && mau.MEM_REQ && !io_hit) || state == WR_SETUP;
    mau_wait_counter u_wait (
        .clk  (Clk),
        .rst_n(Reset),
        .start(cnt_start),
        .count(4'(WAIT_CYCLES - 1)),
        .last (cnt_last)
    );
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            mar   <= '0;
            mdr   <= '0;
            ce_n  <= 1'b1;
            oe_n  <= 1'b1;
            we_n  <= 1'b1;
            ready <= 1'b0;
            busy  <= 1'b0;
`ifdef MAU_IO_MAP_EN
            mau.hex_out <= '0;
`endif
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    mar <= mar_nx;
                    mdr <= mdr_nx;
                    if (mau.MEM_REQ) begin
                        busy <= 1'b1;
                        if (io_hit) begin
                            state <= DONE;
                            ready <= 1'b1;
`ifdef MAU_IO_MAP_EN
                            if (mau.MEM_WE) mau.hex_out <= mdr_nx;
                            else mdr <= mau.sw_in;
`endif
                        end else if (mau.MEM_WE) begin
                            state <= WR_SETUP;
                            ce_n  <= 1'b0;
                        end else begin
                            state <= RD_WAIT;
                            ce_n  <= 1'b0;
                            oe_n  <= 1'b0;
                        end
                    end
                end
                RD_WAIT: if (cnt_last) begin
                    mdr   <= mau.sram_rdata;
                    state <= DONE;
                    ce_n  <= 1'b1;
                    oe_n  <= 1'b1;
                    ready <= 1'b1;
                end
                WR_SETUP: begin
                    state <= WR_PULSE;
                    we_n  <= 1'b0;
                end
                WR_PULSE: if (cnt_last) begin
                    state <= DONE;
                    ce_n  <= 1'b1;
                    we_n  <= 1'b1;
                    ready <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign mau.MAR_out    = mar;
    assign mau.MDR_out    = mdr;
    assign mau.sram_wdata = mdr;
    assign mau.sram_addr  = ADDR_W'(mar);
    assign mau.sram_ce_n  = ce_n;
    assign mau.sram_oe_n  = oe_n;
    assign mau.sram_we_n  = we_n;
    assign mau.MEM_READY  = ready;
    assign mau.BUSY       = busy;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized accesses against a transaction-level MAR/MDR/memory model.
module tb_mem_access_unit;
    localparam int W  = 2;
    localparam int AW = 20;
`ifdef MAU_IO_MAP_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(AW)) mif ();
    mem_access_unit #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (.Clk(clk), .Reset(rst_n), .mau(mif));

    logic [15:0] dev_mem [65536];
    logic [15:0] ref_mem [65536];
    logic [15:0] m_mar, m_mdr, m_hex;
    int n_chk = 0;
    int n_pass = 0;

    always_comb mif.sram_rdata = (!mif.sram_ce_n && !mif.sram_oe_n) ? dev_mem[mif.sram_addr[15:0]] : 16'hDEAD;
    always @(posedge clk) if (rst_n && !mif.sram_ce_n && !mif.sram_we_n) dev_mem[mif.sram_addr[15:0]] <= mif.sram_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        mif.BUS = '0; mif.LD_MAR = 1'b0; mif.LD_MDR = 1'b0; mif.MEM_REQ = 1'b0; mif.MEM_WE = 1'b0;
    endtask

    task automatic access(input logic [15:0] a, input logic [15:0] d, input bit we, input bit poke);
        int lat, strobe, ce_low, wbad;
        bit io;
        logic [15:0] sw;
        io = IO_EN && a == 16'hFFFF;
        sw = 16'($urandom);
`ifdef MAU_IO_MAP_EN
        mif.sw_in = sw;
`endif
        @(negedge clk);
        mif.BUS = a; mif.LD_MAR = 1'b1;
        @(negedge clk);
        mif.LD_MAR = 1'b0; mif.BUS = d; mif.LD_MDR = we; mif.MEM_REQ = 1'b1; mif.MEM_WE = we;
        m_mar = a;
        if (we) begin
            m_mdr = d;
            if (io) m_hex = d; else ref_mem[a] = d;
        end else m_mdr = io ? sw : ref_mem[a];
        lat = 0; strobe = 0; ce_low = 0; wbad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!(we ? mif.sram_we_n : mif.sram_oe_n)) strobe++;
            if (!mif.sram_ce_n) ce_low++;
            if (we && !mif.sram_we_n && mif.sram_wdata !== d) wbad++;
            if (mif.MEM_READY) begin
                lat = k;
                break;
            end
            if (poke) begin
                mif.BUS = 16'($urandom); mif.LD_MAR = 1'b1; mif.LD_MDR = 1'b1;
                mif.MEM_REQ = 1'b1; mif.MEM_WE = 1'($urandom);
            end else idle_inputs();
        end
        idle_inputs();
        check("latency", lat, io ? 1 : (we ? W + 2 : W + 1));
        check("strobe_cycles", strobe, io ? 0 : W);
        check("ce_cycles", ce_low, io ? 0 : (we ? W + 1 : W));
        check("wdata_stable", wbad, 0);
        check("mdr", mif.MDR_out, m_mdr);
        check("mar", mif.MAR_out, m_mar);
        check("sram_addr", mif.sram_addr, {4'h0, a});
`ifdef MAU_IO_MAP_EN
        check("hex_out", mif.hex_out, m_hex);
`endif
        @(negedge clk);
        check("ready_one_cycle", mif.MEM_READY, 1'b0);
        check("idle_after", mif.BUSY, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rdy, first, second;
        for (int i = 0; i < 65536; i++) begin
            dev_mem[i] = 16'h0;
            ref_mem[i] = 16'h0;
        end
        for (int i = 16'h3000; i < 16'h3020; i++) begin
            ref_mem[i] = 16'($urandom);
            dev_mem[i] = ref_mem[i];
        end
        m_hex = 16'h0;
        idle_inputs();
`ifdef MAU_IO_MAP_EN
        mif.sw_in = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_ce_n", mif.sram_ce_n, 1'b1);
        check("rst_oe_n", mif.sram_oe_n, 1'b1);
        check("rst_we_n", mif.sram_we_n, 1'b1);
        check("rst_busy", mif.BUSY, 1'b0);
        check("rst_ready", mif.MEM_READY, 1'b0);
        check("rst_mar", mif.MAR_out, 16'h0);
        check("rst_mdr", mif.MDR_out, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", mif.BUSY, 1'b0);
        check("idle_ce_n", mif.sram_ce_n, 1'b1);

        // Reset dropped in the middle of a read wait.
        mif.BUS = 16'h3000; mif.LD_MAR = 1'b1; mif.MEM_REQ = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("midrd_oe_low", mif.sram_oe_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrd_rst_ce_n", mif.sram_ce_n, 1'b1);
        check("midrd_rst_oe_n", mif.sram_oe_n, 1'b1);
        check("midrd_rst_busy", mif.BUSY, 1'b0);
        check("midrd_rst_mdr", mif.MDR_out, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy = 0;
        repeat (6) begin
            @(negedge clk);
            if (mif.MEM_READY) rdy++;
        end
        check("midrd_no_ready", rdy, 0);
        m_mar = 16'h0; m_mdr = 16'h0;

        ref_mem[16'h3000] = 16'h1234;
        dev_mem[16'h3000] = 16'h1234;
        access(16'h3000, 16'h0, 1'b0, 1'b0);
        access(16'h3000, 16'hBEEF, 1'b1, 1'b1);
        access(16'h3000, 16'h0, 1'b0, 1'b1);

        // MEM_REQ held high across two reads.
        @(negedge clk);
        mif.MEM_REQ = 1'b1; mif.MEM_WE = 1'b0;
        rdy = 0; first = 0; second = 0;
        for (int k = 1; k <= 3 * W + 8; k++) begin
            @(negedge clk);
            if (k == W + 3) mif.MEM_REQ = 1'b0;
            if (mif.MEM_READY) begin
                rdy++;
                if (first == 0) first = k; else second = k;
            end
        end
        check("b2b_pulses", rdy, 2);
        check("b2b_first", first, W + 1);
        check("b2b_gap", second - first, W + 2);
        check("b2b_mdr", mif.MDR_out, ref_mem[m_mar]);

`ifdef MAU_IO_MAP_EN
        access(16'hFFFF, 16'h0, 1'b0, 1'b0);
        access(16'hFFFF, 16'h0042, 1'b1, 1'b0);
`else
        access(16'hFFFF, 16'h0042, 1'b1, 1'b0);
        access(16'hFFFF, 16'h0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 30; i++)
            access(16'h3000 + 16'($urandom_range(0, 31)), 16'($urandom), 1'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
